seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit, 7-segment display.
- Drives the 4:1 segment mux's select and enable, and consumes the mux's 7-bit output.
- Registers that output onto the segment pins and drives the per-digit common (anode) lines.
- Inserts a blanking gap between digits to suppress ghosting, skips masked digits, and pulses once per completed frame.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/seven_seg_slot_counter.sv | 35 +++
 rtl/seven_seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the 4-digit seven-segment scan controller.
// Used by both the controller RTL and the bench model.
package seven_seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIGITS_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Next set mask bit strictly above index, wrapping 3->0.
  // Passing index=3 yields the lowest set bit.
  function automatic logic [1:0] next_enabled_digit(
    input logic [1:0] index,
    input logic [3:0] mask
  );
    logic [1:0] cand;
    logic       found;
    next_enabled_digit = index;
    found = 1'b0;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      cand = index + 2'(i);
      if (!found && mask[cand]) begin
        next_enabled_digit = cand;
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/seven_seg_slot_counter.sv
// Per-digit slot prescaler: counts 0..CLK_DIV-1 and flags
// the last blanking cycle and the last cycle of the slot.
module seven_seg_slot_counter #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  output logic [$clog2(CLK_DIV)-1:0] o_count,
  output logic                       o_blank_done,
  output logic                       o_slot_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_slot_done) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count      = r_count;
  assign o_blank_done = (r_count == BLANK_LAST);
  assign o_slot_done  = (r_count == SLOT_LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller.
// Define SEVEN_SEG_SCAN_DIMMING_EN to add the brightness input.
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_WIDTH      = 7,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [3:0]           digit_mask,
  input  logic [SEG_WIDTH-1:0] mux_out,
`ifdef SEVEN_SEG_SCAN_DIMMING_EN
  input  logic [2:0]           brightness,
`endif
  output logic [1:0]           mux_select,
  output logic                 mux_enable,
  output logic [3:0]           digit_n,
  output logic [SEG_WIDTH-1:0] seg_n,
  output logic                 frame_tick
);

  import seven_seg_pkg::*;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [SEG_WIDTH-1:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? {SEG_WIDTH{1'b1}}
                          : {SEG_WIDTH{1'b0}};

  state_e               r_state;
  state_e               w_next_state;
  logic [1:0]           r_index;
  logic [1:0]           w_next_index;
  logic                 r_frame_tick;
  logic                 w_tick;
  logic [SEG_WIDTH-1:0] r_seg;
  logic [CW-1:0]        w_count;
  logic                 w_blank_done;
  logic                 w_slot_done;
  logic                 w_clr;
  logic                 w_lit;

  assign w_clr = (r_state == IDLE) || !run;

  seven_seg_slot_counter #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_counter (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_clr        (w_clr),
    .o_count      (w_count),
    .o_blank_done (w_blank_done),
    .o_slot_done  (w_slot_done)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_index = r_index;
    w_tick       = 1'b0;
    if (!run) begin
      w_next_state = IDLE;
      w_next_index = 2'd0;
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          if (digit_mask != 4'b0000) begin
            w_next_state = BLANK;
            w_next_index = next_enabled_digit(2'd3, digit_mask);
          end
        end
        (r_state == BLANK): begin
          if (w_blank_done) w_next_state = SHOW;
        end
        (r_state == SHOW): begin
          if (w_slot_done) begin
            if (digit_mask == 4'b0000) begin
              w_next_state = IDLE;
              w_next_index = 2'd0;
            end else begin
              w_next_state = BLANK;
              w_next_index = next_enabled_digit(r_index, digit_mask);
              w_tick       = (w_next_index <= r_index);
            end
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_index = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_index      <= 2'd0;
      r_frame_tick <= 1'b0;
      r_seg        <= '0;
    end else begin
      r_state      <= w_next_state;
      r_index      <= w_next_index;
      r_frame_tick <= w_tick;
      r_seg        <= (r_state == IDLE) ? '0 : mux_out;
    end
  end

`ifdef SEVEN_SEG_SCAN_DIMMING_EN
  localparam int SUB = (CLK_DIV - BLANK_CYCLES) / 8;

  logic [2:0] r_bright;
  int         w_sub;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bright <= 3'd0;
    end else if (r_state == BLANK && w_blank_done) begin
      r_bright <= brightness;
    end
  end

  // Sub-window index within SHOW; only meaningful while in SHOW.
  always_comb begin
    w_sub = (int'(w_count) - BLANK_CYCLES) / SUB;
    w_lit = (w_sub <= int'(r_bright));
  end
`else
  logic w_unused_count;
  assign w_unused_count = ^w_count;
  assign w_lit = 1'b1;
`endif

  assign mux_select = r_index;
  assign mux_enable = (r_state != IDLE);
  assign frame_tick = r_frame_tick;
  assign digit_n    = (r_state == SHOW && w_lit)
                      ? ~(4'b0001 << r_index) : DIGITS_OFF;
  assign seg_n      = (r_state != SHOW) ? SEG_OFF
                    : (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2);
// with SEVEN_SEG_SCAN_DIMMING_EN it runs the CLK_DIV=18 dimming case.
module tb_seven_seg_scan_ctrl;

`ifdef SEVEN_SEG_SCAN_DIMMING_EN
  localparam int CDIV    = 18;
  localparam int LIT_END = 6;
`else
  localparam int CDIV    = 8;
  localparam int LIT_END = 8;
`endif
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic [3:0] digit_mask;
  logic [6:0] mux_out;
  logic [1:0] mux_select;
  logic       mux_enable;
  logic [3:0] digit_n;
  logic [6:0] seg_n;
  logic       frame_tick;
`ifdef SEVEN_SEG_SCAN_DIMMING_EN
  logic [2:0] brightness;
`endif

  int checks   = 0;
  int failures = 0;

  logic [6:0] tbl [4] = '{7'h06, 7'h5B, 7'h3F, 7'h4F};

  always #5 clk = ~clk;

  always_comb mux_out = mux_enable ? tbl[mux_select] : 7'h00;

  seven_seg_scan_ctrl #(
    .CLK_DIV        (CDIV),
    .BLANK_CYCLES   (BLK),
    .SEG_WIDTH      (7),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .digit_mask (digit_mask),
    .mux_out    (mux_out),
`ifdef SEVEN_SEG_SCAN_DIMMING_EN
    .brightness (brightness),
`endif
    .mux_select (mux_select),
    .mux_enable (mux_enable),
    .digit_n    (digit_n),
    .seg_n      (seg_n),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_digit"}, digit_n, 4'hF);
    chk({tag, "_en"}, mux_enable, 1'b0);
    chk({tag, "_sel"}, mux_select, 2'd0);
    chk({tag, "_seg"}, seg_n, 7'h7F);
    chk({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  // Samples positions p0..p1 of a slot lighting digit d.
  task automatic run_slot(input int d, input int p0, input int p1,
                          input bit tick0);
    logic [3:0] ed;
    logic [6:0] es;
    for (int p = p0; p <= p1; p++) begin
      @(negedge clk);
      ed = (p >= BLK && p < LIT_END) ? ~(4'b0001 << d) : 4'hF;
      es = (p >= BLK) ? ~tbl[d] : 7'h7F;
      chk($sformatf("d%0d_p%0d_digit", d, p), digit_n, ed);
      chk($sformatf("d%0d_p%0d_seg", d, p), seg_n, es);
      chk($sformatf("d%0d_p%0d_tick", d, p), frame_tick,
          (tick0 && p == 0));
      chk($sformatf("d%0d_p%0d_sel", d, p), mux_select, d);
      chk($sformatf("d%0d_p%0d_en", d, p), mux_enable, 1'b1);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    run        = 1'b0;
    digit_mask = 4'b0000;
`ifdef SEVEN_SEG_SCAN_DIMMING_EN
    brightness = 3'd1;
`endif
    repeat (2) @(negedge clk);
    expect_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);
    expect_idle("post_reset");

`ifdef SEVEN_SEG_SCAN_DIMMING_EN
    digit_mask = 4'b0001;
    run = 1'b1;
    run_slot(0, 0, CDIV - 1, 1'b0);
    run_slot(0, 0, CDIV - 1, 1'b1);
`else
    digit_mask = 4'b1111;
    run = 1'b1;
    run_slot(0, 0, 7, 1'b0);
    run_slot(1, 0, 7, 1'b0);
    run_slot(2, 0, 7, 1'b0);
    run_slot(3, 0, 7, 1'b0);

    digit_mask = 4'b0101;
    run_slot(0, 0, 7, 1'b1);
    run_slot(2, 0, 7, 1'b0);
    run_slot(0, 0, 7, 1'b1);
    run_slot(2, 0, 3, 1'b0);
    digit_mask = 4'b1000;
    run_slot(2, 4, 7, 1'b0);
    run_slot(3, 0, 7, 1'b0);
    run_slot(3, 0, 7, 1'b1);
    run_slot(3, 0, 3, 1'b1);

    digit_mask = 4'b0000;
    run_slot(3, 4, 7, 1'b0);
    @(negedge clk);
    expect_idle("mask0_idle");
    @(negedge clk);
    expect_idle("mask0_hold");

    digit_mask = 4'b0010;
    run_slot(1, 0, 7, 1'b0);
    run_slot(1, 0, 4, 1'b1);
    run = 1'b0;
    @(negedge clk);
    expect_idle("run_drop");

    run = 1'b1;
    run_slot(1, 0, 7, 1'b0);
    run = 1'b0;
    @(negedge clk);
    expect_idle("run_vs_boundary");

    run = 1'b1;
    run_slot(1, 0, 4, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_digit", digit_n, 4'hF);
    chk("async_rst_en", mux_enable, 1'b0);
    chk("async_rst_seg", seg_n, 7'h7F);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_idle("after_async_rst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
